// File: rtl/led_step_sequencer_pkg.sv
// Shared state encoding and parameter defaults for the LED step sequencer.
package led_step_sequencer_pkg;
  localparam int NUM_STEPS_DEF = 4;
  localparam int DW_DEF        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/led_step_sequencer_dwell_timer.sv
// Per-step dwell counter: counts 0..dwell_eff-1 while enabled, wraps on terminal count.
module dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          enable,
  input  logic [DW-1:0] dwell_eff,
  output logic          tc
);
  logic [DW-1:0] timer_q, timer_d;

  // dwell_eff is never zero, so the subtraction cannot underflow
  assign tc = (timer_q == dwell_eff - DW'(1));

  always_comb begin
    timer_d = timer_q;
    if (load)        timer_d = '0;
    else if (enable) timer_d = tc ? '0 : timer_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
endmodule

// File: rtl/led_step_sequencer.sv
// Steps an LED pattern index up or down with a programmable dwell, one-shot or looping,
// with pause/abort control. All outputs are registered.
module led_step_sequencer
  import led_step_sequencer_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic          loop,
  input  logic          dir,
  input  logic [DW-1:0] dwell,
  output logic [31:0]   num,
  output logic          busy,
  output logic          step_strobe,
  output logic          done
);
  localparam int IW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STEPS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] num_q, num_d;
  logic          busy_q, busy_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          loop_q, loop_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic [DW-1:0] dwell_eff;
  logic [IW-1:0] next_idx;
  logic          at_last, tc, tmr_load, tmr_en;

  assign dwell_eff = (dwell_q == '0) ? DW'(1) : dwell_q;
  assign at_last   = dir_q ? (num_q == '0) : (num_q == LAST_IDX);

  always_comb begin
    next_idx = num_q;
    if (dir_q) next_idx = (num_q == '0) ? LAST_IDX : num_q - IW'(1);
    else       next_idx = (num_q == LAST_IDX) ? '0 : num_q + IW'(1);
  end

  dwell_timer #(.DW(DW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .enable    (tmr_en),
    .dwell_eff (dwell_eff),
    .tc        (tc)
  );

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    loop_d   = loop_q;
    dir_d    = dir_q;
    dwell_d  = dwell_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    if (abort) begin
      state_d  = ST_IDLE;
      num_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          num_d    = '0;
          tmr_load = 1'b1;
          if (start) begin
            state_d  = ST_RUN;
            loop_d   = loop;
            dir_d    = dir;
            dwell_d  = dwell;
            num_d    = dir ? LAST_IDX : '0;
            strobe_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (tc && !pause) begin
            if (at_last && !loop_q) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              tmr_load = 1'b1;
            end else begin
              num_d    = next_idx;
              strobe_d = 1'b1;
              tmr_en   = 1'b1;
            end
          end else begin
            // the pausing cycle still counts, but a pending terminal count is held for resume
            tmr_en = !tc;
            if (pause) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (!pause) state_d = ST_RUN;
        ST_DONE: begin
          state_d  = ST_IDLE;
          num_d    = '0;
          tmr_load = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= 1'b0;
      dir_q    <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      loop_q   <= loop_d;
      dir_q    <= dir_d;
      dwell_q  <= dwell_d;
    end
  end

  assign num         = 32'(num_q);
  assign busy        = busy_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;
endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed bench: each step pushes the per-cycle expected outputs, then the cycle loop pops and checks them.
module tb_led_step_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, pause, abort, loop, dir;
  logic [15:0] dwell;
  logic [31:0] num;
  logic        busy, step_strobe, done;

  always #5 clk = ~clk;

  led_step_sequencer #(.NUM_STEPS(4), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .loop(loop), .dir(dir), .dwell(dwell),
    .num(num), .busy(busy), .step_strobe(step_strobe), .done(done)
  );

  typedef struct packed {
    logic [31:0] num;
    logic        busy;
    logic        stb;
    logic        done;
  } obs_t;

  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string tag   = "reset";

  function automatic void push(int n, bit b, bit s, bit d);
    obs_t e;
    e.num = 32'(n); e.busy = b; e.stb = s; e.done = d;
    exp_q.push_back(e);
  endfunction

  // one step held for `cycles` cycles, strobe on the first
  function automatic void push_step(int idx, int cycles);
    for (int k = 0; k < cycles; k++) push(idx, 1'b1, k == 0, 1'b0);
  endfunction

  task automatic check();
    obs_t o, e;
    o.num = num; o.busy = busy; o.stb = step_strobe; o.done = done;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: output num=%0d observed with no expected entry queued", tag, o.num);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: observed num=%0d busy=%b stb=%b done=%b, expected num=%0d busy=%b stb=%b done=%b",
               tag, o.num, o.busy, o.stb, o.done, e.num, e.busy, e.stb, e.done);
      end
    end
  endtask

  // advance n clocks; start/abort are single-cycle pulses
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    loop = 1'b0; dir = 1'b0; dwell = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    push(0, 0, 0, 0); check();
    rst = 1'b0;
    push(0, 0, 0, 0); cyc(1);

    // one-shot up, dwell 3
    tag = "oneshot_up_d3";
    dwell = 16'd3; loop = 1'b0; dir = 1'b0; start = 1'b1;
    for (int s = 0; s < 4; s++) push_step(s, 3);
    push(3, 0, 0, 1);
    push(0, 0, 0, 0);
    cyc(14);

    // looping down, dwell 2; settings changes and a start while busy are ignored
    tag = "loop_down_d2";
    dwell = 16'd2; loop = 1'b1; dir = 1'b1; start = 1'b1;
    push_step(3, 2); push_step(2, 2); push_step(1, 2); push_step(0, 2);
    push_step(3, 2); push(2, 1, 1, 0);
    cyc(3);
    start = 1'b1; dir = 1'b0; loop = 1'b0; dwell = 16'd7;
    cyc(8);
    tag = "loop_abort";
    abort = 1'b1;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    cyc(2);

    // dwell 0 behaves as 1; start in DONE is ignored
    tag = "dwell_zero";
    dwell = 16'd0; loop = 1'b0; dir = 1'b0; start = 1'b1;
    for (int s = 0; s < 4; s++) push_step(s, 1);
    push(3, 0, 0, 1);
    cyc(5);
    tag = "start_in_done";
    start = 1'b1;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    cyc(2);

    // pause for 5 cycles in step 1 at timer=2
    tag = "pause_mid_step";
    dwell = 16'd4; start = 1'b1;
    push_step(0, 4);
    push(1, 1, 1, 0); push(1, 1, 0, 0); push(1, 1, 0, 0);
    cyc(7);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) push(1, 1, 0, 0);
    cyc(5);
    pause = 1'b0;
    push(1, 1, 0, 0);
    push_step(2, 4); push_step(3, 4);
    push(3, 0, 0, 1); push(0, 0, 0, 0);
    cyc(11);

    // pause landing on the terminal count defers the advance until resume
    tag = "pause_at_tc";
    dwell = 16'd2; start = 1'b1;
    push(0, 1, 1, 0); push(0, 1, 0, 0);
    cyc(2);
    pause = 1'b1;
    push(0, 1, 0, 0); push(0, 1, 0, 0);
    cyc(2);
    pause = 1'b0;
    push(0, 1, 0, 0); push(1, 1, 1, 0); push(1, 1, 0, 0);
    cyc(3);
    tag = "abort_no_done";
    abort = 1'b1;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    cyc(2);

    // start together with abort in IDLE is ignored
    tag = "start_abort_idle";
    start = 1'b1; abort = 1'b1;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    cyc(2);

    // reset during step 2 gives IDLE without a done pulse
    tag = "rst_mid_seq";
    dwell = 16'd1; start = 1'b1;
    push(0, 1, 1, 0); push(1, 1, 1, 0); push(2, 1, 1, 0);
    cyc(3);
    rst = 1'b1;
    push(0, 0, 0, 0);
    cyc(1);
    rst = 1'b0;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_step_sequencer.md
LED_STEP_SEQUENCER -- requirements
Module: led_step_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 4, SHALL set the number of pattern steps; num SHALL range 0..NUM_STEPS-1.
REQ-002 Parameter DW, default 16, SHALL set the width of the dwell input and dwell timer.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request that begins a sequence from IDLE.
REQ-006 pause  input  1  SHALL, while high, freeze sequence progress (level-sensitive).
REQ-007 abort  input  1  SHALL, when high, terminate any sequence in progress.
REQ-008 loop  input  1  SHALL select repeat (1) or one-shot (0) operation; sampled on accepted start.
REQ-009 dir  input  1  SHALL select the step order: 0 = up (0,1,2,3), 1 = down (3,2,1,0); sampled on accepted start.
REQ-010 dwell  input  DW  SHALL give the cycles held per step; sampled on accepted start; 0 SHALL be treated as 1.
REQ-011 num  output  32  SHALL be the current step index feeding the LED pattern decoder; bits above the index width SHALL be 0.
REQ-012 busy  output  1  SHALL be high in RUN and PAUSE.
REQ-013 step_strobe  output  1  SHALL pulse for one cycle in the first cycle num shows a new step, including the first step.
REQ-014 done  output  1  SHALL pulse for one cycle when a one-shot sequence completes.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE and DONE.
REQ-016 IDLE: num=0, busy=0, timer=0; start with abort low SHALL move to RUN next cycle, with num = 0 (dir=0) or NUM_STEPS-1 (dir=1) and step_strobe=1.
REQ-017 RUN: timer SHALL increment each cycle; when timer = dwell_eff-1 it SHALL clear and num SHALL advance, so each step is visible for exactly dwell_eff cycles.
REQ-018 Advance when loop=1: up wraps NUM_STEPS-1 -> 0; down wraps 0 -> NUM_STEPS-1; step_strobe=1 on each advance.
REQ-019 Advance off the last step with loop=0: state SHALL go to DONE, done=1 for that one cycle, and num SHALL hold the last step; the next cycle SHALL be IDLE with num=0.
REQ-020 pause high in RUN: state SHALL go to PAUSE next cycle with timer and num frozen; pause low SHALL return to RUN and resume with the remaining dwell (total cycles per step excluding paused cycles = dwell_eff).
REQ-021 pause high in the same cycle as a step's terminal count: pause SHALL win, and the advance SHALL occur on the first RUN cycle after resume.
REQ-022 abort SHALL have priority over start, pause and advance: from any state go to IDLE next cycle with num=0 and timer=0; done and step_strobe SHALL not pulse.
REQ-023 start SHALL be ignored when busy=1 or in DONE; loop, dir and dwell changes SHALL be ignored while busy=1.
REQ-024 start with abort high in the same cycle SHALL be ignored.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-026 rst SHALL override all inputs and force IDLE, num=0, busy=0, step_strobe=0, done=0, timer=0 and latched loop/dir/dwell=0 at the next edge.
REQ-027 rst asserted mid-sequence SHALL abort the sequence with no done pulse.

Structure
REQ-028 A shared package/header SHALL hold the state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3) and the NUM_STEPS and DW defaults.
REQ-029 The dwell timer SHALL be a sub-module dwell_timer (inputs: load, enable, dwell_eff; output: terminal count).
REQ-030 num SHALL connect directly to the existing LED pattern decoder; the sequencer SHALL contain no pattern decoding.

Verification
REQ-031 dwell=3, loop=0, dir=0, start -> num 0,0,0,1,1,1,2,2,2,3,3,3; done pulses when leaving step 3; IDLE next cycle; 4 step_strobes.
REQ-032 dwell=2, loop=1, dir=1 -> num 3,3,2,2,1,1,0,0,3,3 ...; done never pulses; abort -> num=0 and busy=0 next cycle.
REQ-033 dwell=0 -> each step held exactly 1 cycle (0,1,2,3), then done.
REQ-034 dwell=4, pause high for 5 cycles during step 1 at timer=2 -> step 1 visible for 4 RUN cycles plus 5 paused cycles; no step_strobe during the pause.
REQ-035 start while busy, start+abort in IDLE, and rst during step 2 -> the starts are ignored; rst gives IDLE and num=0 with no done.
REQ-036 Pause asserted at terminal count -> no advance until pause drops; the advance follows on the next RUN cycle.
